execute_stage: RTL

Execute stage of the pipelined MIPS core. Sits directly downstream of the ID/EX pipeline register. Selects forwarded operands, performs the ALU operation or an optional iterative 32-cycle multiply, resolves the destination register, and registers everything into the EX/MEM pipeline register that feeds the memory stage. It also drives the hazard unit with `WriteRegE` and a multiply-busy stall request.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/seq_multiplier.sv | 78 +++++++
 rtl/execute_stage.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operations, forward
// selects and the iterative multiplier state.
package mips_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one step per cycle for WIDTH cycles,
// then a single DONE cycle presenting the low WIDTH bits of the product.
module seq_multiplier
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t     state, state_n;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] acc, mcand, mplier;

  // State register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= MUL_IDLE;
    else        state <= state_n;
  end

  // Next state and busy/done flags
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      MUL_IDLE: begin
        if (start) begin
          busy    = 1'b1;
          state_n = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_n = MUL_DONE;
      end
      MUL_DONE: begin
        done    = 1'b1;
        state_n = MUL_IDLE;
      end
      default: state_n = MUL_IDLE;
    endcase
  end

  // Operand load on start, then one shift-add step per BUSY cycle
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      if (state == MUL_IDLE && start) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
      end else if (state == MUL_BUSY) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: forward muxes, ALU, destination select and the
// EX/MEM pipeline register. Define EXECUTE_MUL_EN to build in the
// iterative multiplier; otherwise MUL yields 0 in a single cycle.
module execute_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [4:0]       RtE,
  input  logic [4:0]       RdE,
  input  logic [WIDTH-1:0] signImmE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             ALUSrcE,
  input  logic             RegDstE,
  input  logic [2:0]       ALUControlE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  output logic [4:0]       WriteRegE,
  output logic             MulBusyE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [4:0]       WriteRegM
);

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_out;
  logic             nxt_rw, nxt_mr, nxt_mw;
  logic [WIDTH-1:0] nxt_alu, nxt_wd;
  logic [4:0]       nxt_wr;

  // Operand forwarding and immediate select
  always_comb begin
    unique case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    unique case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUOutM;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? signImmE : fwd_b;
  end

  assign WriteRegE = RegDstE ? RdE : RtE;

  // Single-cycle ALU; MUL contributes nothing here
  always_comb begin
    alu_out = '0;
    unique case (ALUControlE)
      ALU_AND:  alu_out = src_a & src_b;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_ADD:  alu_out = src_a + src_b;
      ALU_ANDN: alu_out = src_a & ~src_b;
      ALU_ORN:  alu_out = src_a | ~src_b;
      ALU_SUB:  alu_out = src_a - src_b;
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default:  alu_out = '0;
    endcase
  end

`ifdef EXECUTE_MUL_EN
  logic             mul_req, mul_accept, mul_pend, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod, cap_b;
  logic [4:0]       cap_wr;
  logic             cap_rw, cap_mr, cap_mw;

  assign mul_req    = (ALUControlE == ALU_MUL) && (RegWriteE || MemWriteE || MemtoRegE);
  // mul_pend covers BUSY and DONE so a MUL held in ID/EX is not re-accepted
  assign mul_accept = mul_req && !mul_pend && Reset;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .CLK     (CLK),
    .Reset   (Reset),
    .start   (mul_accept),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign MulBusyE = mul_busy;

  // Track an accepted multiply and capture its writeback context
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mul_pend <= 1'b0;
      cap_b    <= '0;
      cap_wr   <= '0;
      cap_rw   <= 1'b0;
      cap_mr   <= 1'b0;
      cap_mw   <= 1'b0;
    end else if (mul_done) begin
      mul_pend <= 1'b0;
    end else if (mul_accept) begin
      mul_pend <= 1'b1;
      cap_b    <= src_b;
      cap_wr   <= WriteRegE;
      cap_rw   <= RegWriteE;
      cap_mr   <= MemtoRegE;
      cap_mw   <= MemWriteE;
    end
  end
`else
  assign MulBusyE = 1'b0;
`endif

  // EX/MEM next value: E-stage, multiply bubble, or multiply result
  always_comb begin
    nxt_rw  = RegWriteE;
    nxt_mr  = MemtoRegE;
    nxt_mw  = MemWriteE;
    nxt_alu = alu_out;
    nxt_wd  = fwd_b;
    nxt_wr  = WriteRegE;
`ifdef EXECUTE_MUL_EN
    if (mul_done) begin
      nxt_rw  = cap_rw;
      nxt_mr  = cap_mr;
      nxt_mw  = cap_mw;
      nxt_alu = mul_prod;
      nxt_wd  = cap_b;
      nxt_wr  = cap_wr;
    end else if (mul_busy) begin
      nxt_rw  = 1'b0;
      nxt_mr  = 1'b0;
      nxt_mw  = 1'b0;
      nxt_alu = '0;
      nxt_wd  = '0;
      nxt_wr  = '0;
    end
`endif
  end

  // EX/MEM pipeline register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      RegWriteM  <= nxt_rw;
      MemtoRegM  <= nxt_mr;
      MemWriteM  <= nxt_mw;
      ALUOutM    <= nxt_alu;
      WriteDataM <= nxt_wd;
      WriteRegM  <= nxt_wr;
    end
  end

endmodule
